// File: rtl/mcp_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Holds the FSM state enum, opcodes, datapath select codes and the control-word struct.
package mcp_pkg;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR,
    ST_EXEC, ST_ALUWB, ST_ADDIEX, ST_ADDIWB, ST_BRANCH, ST_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  localparam logic ALUA_PC  = 1'b0;
  localparam logic ALUA_REG = 1'b1;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SL2 = 2'b11;

  localparam logic [1:0] ALT_ADD   = 2'b00;
  localparam logic [1:0] ALT_SUB   = 2'b01;
  localparam logic [1:0] ALT_FUNCT = 2'b10;

  // mem_state marks the states that wait on mem_ready_i and gates their commits on it.
  typedef struct packed {
    logic       mem_state;
    logic       mem_req;
    logic       mem_we;
    logic       pc_write;
    logic       br_eq;
    logic       br_ne;
    logic       ir_write;
    logic       rf_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       retire;
    logic [1:0] pc_sel;
    logic       iord;
    logic       alu_a;
    logic [1:0] alu_b;
    logic [1:0] alt;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                               op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcp_ctrl_dec.sv
// Combinational state -> control-word decode; no ready/zero/reset gating here.
// Zero latency, no flow control of its own.
module mcp_ctrl_dec
  import mcp_pkg::*;
(
  input  state_t      state_i,
  input  logic [5:0]  op_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_state = 1'b1;
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.iord      = IORD_PC;
        ctrl_o.alu_a     = ALUA_PC;
        ctrl_o.alu_b     = ALUB_FOUR;
        ctrl_o.alt       = ALT_ADD;
        ctrl_o.pc_sel    = PC_ALU;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
      end
      ST_DECODE: begin
        ctrl_o.alu_a = ALUA_PC;
        ctrl_o.alu_b = ALUB_IMM_SL2;
        ctrl_o.alt   = ALT_ADD;
      end
      ST_MEMADR, ST_ADDIEX: begin
        ctrl_o.alu_a = ALUA_REG;
        ctrl_o.alu_b = ALUB_IMM;
        ctrl_o.alt   = ALT_ADD;
      end
      ST_MEMRD: begin
        ctrl_o.mem_state = 1'b1;
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.iord      = IORD_ALUOUT;
      end
      ST_MEMWB: begin
        ctrl_o.rf_we      = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      ST_MEMWR: begin
        ctrl_o.mem_state = 1'b1;
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.mem_we    = 1'b1;
        ctrl_o.iord      = IORD_ALUOUT;
        ctrl_o.retire    = 1'b1;
      end
      ST_EXEC: begin
        ctrl_o.alu_a = ALUA_REG;
        ctrl_o.alu_b = ALUB_REG;
        ctrl_o.alt   = ALT_FUNCT;
      end
      ST_ALUWB: begin
        ctrl_o.rf_we   = 1'b1;
        ctrl_o.reg_dst = 1'b1;
        ctrl_o.retire  = 1'b1;
      end
      ST_ADDIWB: begin
        ctrl_o.rf_we  = 1'b1;
        ctrl_o.retire = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_a  = ALUA_REG;
        ctrl_o.alu_b  = ALUB_REG;
        ctrl_o.alt    = ALT_SUB;
        ctrl_o.pc_sel = PC_ALUOUT;
        ctrl_o.br_eq  = (op_i == OP_BEQ);
        ctrl_o.br_ne  = (op_i == OP_BNE);
        ctrl_o.retire = 1'b1;
      end
      ST_JUMP: begin
        ctrl_o.pc_sel   = PC_JUMP;
        ctrl_o.pc_write = 1'b1;
        ctrl_o.retire   = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mcp_controller.sv
// Multicycle MIPS control FSM with req/ready memory handshake and optional wait timeout.
// Outputs are same-cycle decodes of state; memory states stall until mem_ready_i or timeout.
module mcp_controller
  import mcp_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instr_i32,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_branch_o2,
  output logic        instr_or_data_o,
  output logic        instr_we_o,
  output logic        reg_dst_rtrd_o,
  output logic        mem_to_reg_o,
  output logic        enable_wrf_o,
  output logic        a_alu_input_o,
  output logic [1:0]  b_alu_input_o2,
  output logic [1:0]  alu_alt_ctrl_o2,
  output logic        retire_o,
  output logic        illegal_o,
  output logic        mem_timeout_o
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  ctrl_t           ctrl;
  logic [5:0]      op;
  logic            act, to_hit, unused_instr;

  assign op           = instr_i32[31:26];
  assign unused_instr = ^instr_i32[25:0];

  mcp_ctrl_dec u_dec (
    .state_i (state_q),
    .op_i    (op),
    .ctrl_o  (ctrl)
  );

  // Reset gates every strobe combinationally so enables drop the instant reset rises.
  assign act    = ~reset_i;
  assign to_hit = (MEM_TIMEOUT != 0) && ctrl.mem_state && !mem_ready_i && (cnt_q == TO_LAST);
  assign cnt_d  = (ctrl.mem_state && !mem_ready_i && !to_hit) ? cnt_q + TO_W'(1) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready_i) state_d = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_d = ST_MEMADR;
          OP_RTYPE:       state_d = ST_EXEC;
          OP_BEQ, OP_BNE: state_d = ST_BRANCH;
          OP_ADDI:        state_d = ST_ADDIEX;
          OP_J:           state_d = ST_JUMP;
          default:        state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (op == OP_LW) ? ST_MEMRD : ((op == OP_SW) ? ST_MEMWR : ST_FETCH);
      ST_MEMRD: begin
        if (mem_ready_i)  state_d = ST_MEMWB;
        else if (to_hit)  state_d = ST_FETCH;
      end
      ST_MEMWR:  if (mem_ready_i || to_hit) state_d = ST_FETCH;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req_o       = act & ctrl.mem_req;
  assign mem_we_o        = act & ctrl.mem_we & ~to_hit;
  assign pc_we_o         = act & ~to_hit &
                           ((ctrl.pc_write & (mem_ready_i | ~ctrl.mem_state)) |
                            (ctrl.br_eq & zero_i) | (ctrl.br_ne & ~zero_i));
  assign instr_we_o      = act & ctrl.ir_write & mem_ready_i;
  assign enable_wrf_o    = act & ctrl.rf_we;
  assign retire_o        = act & ctrl.retire & (mem_ready_i | ~ctrl.mem_state);
  assign illegal_o       = act & (state_q == ST_DECODE) & ~op_legal(op);
  assign mem_timeout_o   = act & to_hit;
  assign pc_branch_o2    = ctrl.pc_sel;
  assign instr_or_data_o = ctrl.iord;
  assign reg_dst_rtrd_o  = ctrl.reg_dst;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign a_alu_input_o   = ctrl.alu_a;
  assign b_alu_input_o2  = ctrl.alu_b;
  assign alu_alt_ctrl_o2 = ctrl.alt;

endmodule
